// File: rtl/spi_master_shifter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// spi_master_shifter : SPI mode-0 master shift engine, SCLK divided from clk_i
// Revision 1.0
// ----------------------------------------------------------------------------
module spi_master_shifter #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              tx_valid_i,
  input  logic [DATA_W-1:0] tx_data_i,
  output logic              tx_ready_o,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              spi_sclk_o,
  output logic              spi_cs_n_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]   rx_sr_q, rx_sr_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                rx_valid_q, rx_valid_d;
  logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                mosi_q, mosi_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bit_cnt_q  <= '0;
      div_cnt_q  <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bit_cnt_q  <= bit_cnt_d;
      div_cnt_q  <= div_cnt_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    bit_cnt_d  = bit_cnt_q;
    div_cnt_d  = div_cnt_q;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;

    unique case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          tx_sr_d   = tx_data_i;
          mosi_d    = MSB_FIRST ? tx_data_i[DATA_W-1] : tx_data_i[0];
          cs_n_d    = 1'b0;
          bit_cnt_d = BIT_LAST;
          div_cnt_d = DIV_LAST;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (div_cnt_q == '0) begin
          div_cnt_d = DIV_LAST;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            // Rising edge: target data has been stable for a half period.
            rx_sr_d = MSB_FIRST ? {rx_sr_q[DATA_W-2:0], spi_miso_i}
                                : {spi_miso_i, rx_sr_q[DATA_W-1:1]};
          end else if (bit_cnt_q != '0) begin
            bit_cnt_d = bit_cnt_q - 1'b1;
            tx_sr_d   = MSB_FIRST ? {tx_sr_q[DATA_W-2:0], 1'b0}
                                  : {1'b0, tx_sr_q[DATA_W-1:1]};
            mosi_d    = MSB_FIRST ? tx_sr_q[DATA_W-2] : tx_sr_q[1];
          end else begin
            state_d = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      HOLD: begin
        if (div_cnt_q == '0) begin
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign tx_ready_o = (state_q == IDLE);
  assign busy_o     = (state_q != IDLE);
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign spi_sclk_o = sclk_q;
  assign spi_cs_n_o = cs_n_q;
  assign spi_mosi_o = mosi_q;

endmodule
`default_nettype wire
